// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues credit-limited word requests,
// drops responses made stale by redirects and buffers instructions for decode.
module fetch_controller #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned      BUF_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst_pc,
   output logic [31:0]      inst_data,
   input  logic             inst_ready
);

   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OW = CW + 1;
   localparam int unsigned AW = $clog2(BUF_DEPTH);

   logic [WIDTH-1:0] r_pc;
   logic [CW-1:0]    r_inflight;
   logic [CW-1:0]    r_stale;
   logic [CW-1:0]    r_count;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW-1:0]    r_twptr;
   logic [AW-1:0]    r_trptr;
   logic [WIDTH-1:0] r_tag      [BUF_DEPTH];
   logic [WIDTH-1:0] r_buf_pc   [BUF_DEPTH];
   logic [31:0]      r_buf_data [BUF_DEPTH];

   logic             w_pop;
   logic             w_push;
   logic             w_grant;
   logic             w_stale_hit;
   logic [OW-1:0]    w_occ;
   logic [WIDTH-1:0] w_target;

   assign w_target    = redirect_pc & ~WIDTH'(3);
   assign inst_valid  = (r_count != '0) & ~redirect_valid;
   assign w_pop       = inst_valid & inst_ready;
   assign w_stale_hit = (r_stale != '0);
   // Responses landing in a redirect cycle are discarded here and excluded from the new stale count.
   assign w_push      = imem_rvalid & ~w_stale_hit & ~redirect_valid;

   // Credits cover both in-flight requests and buffered entries, so the FIFO can never overflow.
   assign w_occ    = OW'(r_inflight) + OW'(r_count) - OW'(w_pop);
   assign imem_req = ~rst & ~redirect_valid & (w_occ < OW'(BUF_DEPTH));
   assign w_grant  = imem_req & imem_gnt;

   assign imem_addr = r_pc;
   assign inst_pc   = r_buf_pc[r_rptr];
   assign inst_data = r_buf_data[r_rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_inflight <= '0;
         r_stale    <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_twptr    <= '0;
         r_trptr    <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_grant) - CW'(imem_rvalid);
         if (redirect_valid) begin
            r_pc    <= w_target;
            r_stale <= r_inflight - CW'(imem_rvalid);
            r_count <= '0;
            r_rptr  <= r_wptr;
         end else begin
            if (w_grant)
               r_pc <= r_pc + WIDTH'(4);
            if (imem_rvalid && w_stale_hit)
               r_stale <= r_stale - CW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_pop)
               r_rptr <= r_rptr + AW'(1);
         end
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_grant)
            r_twptr <= r_twptr + AW'(1);
         if (imem_rvalid)
            r_trptr <= r_trptr + AW'(1);
      end
   end

   // The tag queue keeps request addresses in order so each response is paired with its PC.
   always_ff @(posedge clk) begin
      if (w_grant)
         r_tag[r_twptr] <= r_pc;
      if (w_push) begin
         r_buf_pc[r_wptr]   <= r_tag[r_trptr];
         r_buf_data[r_wptr] <= imem_rdata;
      end
   end

   a_rvalid_needs_inflight : assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (r_inflight != '0));
   a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      imem_rvalid |-> (r_count != CW'(BUF_DEPTH)));

endmodule
